// File: rtl/square_pipe_iter.sv
// Iterative shift-add squarer: x in 1.(WL-1), x*x out in 2.(WLO-2), rounded half up.
// One partial product is added per enabled clock; an accepted operand yields a result after WL+1 enabled edges.
module square_pipe_iter #(
    parameter int WL  = 24,
    parameter int WLO = 24
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           CE,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WL-1:0]  din,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WLO-1:0] dout
);

    localparam int AW = 2 * WL;
    localparam int CW = (WL > 1) ? $clog2(WL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RND,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  mcand_sh;
    logic [WL-1:0]  mplier;
    logic [CW-1:0]  cnt;
    logic           last_iter;
    logic [WLO-1:0] rnd_val;

    assign last_iter = (cnt == CW'(WL - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else if (CE) begin
            state <= state_nxt;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (last_iter) state_nxt = RND;
            RND:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The multiplicand is kept pre-shifted, so mcand_sh always equals din << cnt during RUN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            cnt      <= '0;
            dout     <= '0;
        end else if (CE) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand_sh <= {{WL{1'b0}}, din};
                        mplier   <= din;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    if (mplier[cnt]) begin
                        acc <= acc + mcand_sh;
                    end
                    mcand_sh <= mcand_sh << 1;
                    cnt      <= cnt + 1'b1;
                end
                RND: begin
                    dout <= rnd_val;
                end
                default: ;
            endcase
        end
    end

    generate
        if (WLO == AW) begin : g_full
            assign rnd_val = acc;
        end else begin : g_round
            logic [WLO:0] sum;
            assign sum     = {1'b0, acc[AW-1 -: WLO]} + {{WLO{1'b0}}, acc[AW-WLO-1]};
            // A carry out of the rounded word saturates rather than wrapping to zero.
            assign rnd_val = sum[WLO] ? {WLO{1'b1}} : sum[WLO-1:0];
            if (AW - WLO >= 2) begin : g_lsbs
                logic unused_acc_lsbs;
                assign unused_acc_lsbs = ^acc[AW-WLO-2:0];
            end
        end
    endgenerate

endmodule
